// File: rtl/ntt_pkg.sv
// Shared types and constants for the ML-KEM NTT address path.
// Holds Kyber sizes, the stage-count helper and the FSM state enum.
package ntt_pkg;

  localparam int KYBER_LOG_N = 8;
  localparam int KYBER_N     = 1 << KYBER_LOG_N;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } state_e;

  function automatic int num_stages(
    input int log_n,
    input int min_log_len
  );
    return log_n - min_log_len;
  endfunction

endpackage

// File: rtl/ntt_lane_decode.sv
// One butterfly lane: (stage, butterfly index, mode) -> addresses, twiddle.
// Ports: s_i, b_i, is_ntt_i in; addr0_o, addr1_o, zeta_o out.
module ntt_lane_decode
  import ntt_pkg::*;
#(
  parameter int LOG_N = KYBER_LOG_N,
  parameter int SW    = 3
) (
  input  logic [SW-1:0]    s_i,
  input  logic [LOG_N-2:0] b_i,
  input  logic             is_ntt_i,
  output logic [LOG_N-1:0] addr0_o,
  output logic [LOG_N-1:0] addr1_o,
  output logic [LOG_N-2:0] zeta_o
);

  localparam int ZW = LOG_N - 1;

  logic [LOG_N-1:0] l;
  logic [LOG_N-1:0] len;
  logic [LOG_N-1:0] b;
  logic [LOG_N-1:0] blk;
  logic [LOG_N-1:0] off;
  logic [LOG_N-1:0] a0;
  logic [ZW-1:0]    z;

  always_comb begin
    l   = LOG_N'(LOG_N - 1) - LOG_N'(s_i);
    len = LOG_N'(1) << l;
    b   = LOG_N'(b_i);
    blk = b >> l;
    off = b & (len - LOG_N'(1));
    a0  = (blk << (l + LOG_N'(1))) + off;
    // INTT walks twiddles downward: 2^(s+1)-1-blk, wrapping mod 2^ZW
    if (is_ntt_i) begin
      z = (ZW'(1) << s_i) + ZW'(blk);
    end else begin
      z = (ZW'(2) << s_i) - ZW'(1) - ZW'(blk);
    end
  end

  assign addr0_o = a0;
  assign addr1_o = a0 + len;
  assign zeta_o  = z;

endmodule

// File: rtl/ntt_lane_addr_gen.sv
// NTT/INTT schedule generator: LANES butterfly addresses per beat.
// Ports: start/is_ntt/abort/out_ready in; beat, stage, busy, done out.
module ntt_lane_addr_gen
  import ntt_pkg::*;
#(
  parameter  int LOG_N       = KYBER_LOG_N,
  parameter  int MIN_LOG_LEN = 1,
  parameter  int LANES       = 1,
  parameter  int STAGE_GAP   = 0,
  localparam int NS = num_stages(LOG_N, MIN_LOG_LEN),
  localparam int SW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     is_ntt,
  input  logic                     abort,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [LANES*LOG_N-1:0]   addr0,
  output logic [LANES*LOG_N-1:0]   addr1,
  output logic [LANES*(LOG_N-1)-1:0] zeta_idx,
  output logic [SW-1:0]            stage,
  output logic                     stage_last,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = LOG_N - 1;
  localparam logic [BW-1:0] LAST =
    BW'((1 << (LOG_N - 1)) - LANES);
  localparam logic [BW-1:0] STEP = BW'(LANES);
  localparam logic [SW-1:0] S_TOP = SW'(NS - 1);

  state_e          state_q;
  logic            ntt_q;
  logic [SW-1:0]   s_q;
  logic [SW-1:0]   s_d;
  logic [BW-1:0]   bcnt_q;
  logic [3:0]      gap_q;
  logic            last_beat;
  logic            last_stage;

  assign last_beat  = bcnt_q == LAST;
  assign last_stage = ntt_q ? (s_q == S_TOP)
                            : (s_q == '0);
  assign s_d = ntt_q ? s_q + SW'(1) : s_q - SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ntt_q   <= 1'b0;
      s_q     <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      ntt_q   <= 1'b0;
      s_q     <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          ntt_q   <= is_ntt;
          s_q     <= is_ntt ? '0 : S_TOP;
          bcnt_q  <= '0;
        end
        RUN: if (out_ready) begin
          if (!last_beat) begin
            bcnt_q <= bcnt_q + STEP;
          end else if (last_stage) begin
            state_q <= DONE;
          end else begin
            bcnt_q <= '0;
            s_q    <= s_d;
            if (STAGE_GAP > 0) begin
              state_q <= GAP;
              gap_q   <= 4'(STAGE_GAP - 1);
            end
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= RUN;
          else gap_q <= gap_q - 4'd1;
        end
        DONE: begin
          state_q <= IDLE;
          s_q     <= '0;
          bcnt_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = state_q == RUN;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign stage      = out_valid ? s_q : '0;
  assign stage_last = out_valid & last_beat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LOG_N-1:0] a0;
    logic [LOG_N-1:0] a1;
    logic [LOG_N-2:0] z;

    ntt_lane_decode #(
      .LOG_N(LOG_N),
      .SW   (SW)
    ) u_dec (
      .s_i     (s_q),
      .b_i     (bcnt_q + BW'(i)),
      .is_ntt_i(ntt_q),
      .addr0_o (a0),
      .addr1_o (a1),
      .zeta_o  (z)
    );

    assign addr0[i*LOG_N +: LOG_N] =
      out_valid ? a0 : '0;
    assign addr1[i*LOG_N +: LOG_N] =
      out_valid ? a1 : '0;
    assign zeta_idx[i*(LOG_N-1) +: LOG_N-1] =
      out_valid ? z : '0;
  end

endmodule

// File: tb/tb_ntt_lane_addr_gen.sv
// Scoreboard bench for ntt_lane_addr_gen: a 1-lane/no-gap and a
// 4-lane/gap-3 instance, checked against Kyber reference loops.
module tb_ntt_lane_addr_gen;

  localparam int GAP_B   = 3;
  localparam int LANES_B = 4;

  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] z;
    logic [2:0]  s;
    logic        sl;
    logic        fin;
  } beat_t;

  logic clk, rst_n, start, is_ntt, abort, out_ready, sel;
  logic start_a, start_b;

  logic        v_a, sl_a, busy_a, done_a;
  logic [7:0]  a0_a, a1_a;
  logic [6:0]  z_a;
  logic [2:0]  s_a;

  logic        v_b, sl_b, busy_b, done_b;
  logic [31:0] a0_b, a1_b;
  logic [27:0] z_b;
  logic [2:0]  s_b;

  logic        m_v, m_sl, m_busy, m_done;
  logic [31:0] m_a0, m_a1, m_z;
  logic [2:0]  m_s;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  ntt_lane_addr_gen #(
    .LOG_N(8), .MIN_LOG_LEN(1),
    .LANES(1), .STAGE_GAP(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .start(start_a), .is_ntt(is_ntt),
    .abort(abort), .out_ready(out_ready),
    .out_valid(v_a), .addr0(a0_a), .addr1(a1_a),
    .zeta_idx(z_a), .stage(s_a),
    .stage_last(sl_a), .busy(busy_a), .done(done_a)
  );

  ntt_lane_addr_gen #(
    .LOG_N(8), .MIN_LOG_LEN(1),
    .LANES(LANES_B), .STAGE_GAP(GAP_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .start(start_b), .is_ntt(is_ntt),
    .abort(abort), .out_ready(out_ready),
    .out_valid(v_b), .addr0(a0_b), .addr1(a1_b),
    .zeta_idx(z_b), .stage(s_b),
    .stage_last(sl_b), .busy(busy_b), .done(done_b)
  );

  assign m_v    = sel ? v_b : v_a;
  assign m_sl   = sel ? sl_b : sl_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_a0   = sel ? a0_b : {24'b0, a0_a};
  assign m_a1   = sel ? a1_b : {24'b0, a1_a};
  assign m_z    = sel ? {4'b0, z_b} : {25'b0, z_a};
  assign m_s    = sel ? s_b : s_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t q[$];

  int cyc = 0, n_vec = 0, n_err = 0;
  int nbeats = 0, done_cnt = 0, gl = 0;
  bit pend_done = 0, resume = 0;
  int idle_req = 0, idle_seen = 0;
  int tmo_req = 0, tmo_seen = 0;
  bit timed = 0;
  int st_cyc = 0, exp_cyc = 0;

  // Expected beats from the Kyber reference loop nests.
  task automatic gen_run(input bit ntt, input int lanes);
    beat_t e;
    int ln, k, len, s;
    e  = '0;
    ln = 0;
    k  = ntt ? 1 : 127;
    for (int st = 0; st < 7; st++) begin
      len = ntt ? (128 >> st) : (2 << st);
      s   = ntt ? st : 6 - st;
      for (int b0 = 0; b0 < 256; b0 += 2 * len) begin
        for (int j = b0; j < b0 + len; j++) begin
          e.a0[ln*8 +: 8] = 8'(j);
          e.a1[ln*8 +: 8] = 8'(j + len);
          e.z[ln*7 +: 7]  = 7'(k);
          ln++;
          if (ln == lanes) begin
            e.s   = 3'(s);
            e.sl  = (j == 255 - len);
            e.fin = e.sl && (st == 6);
            q.push_back(e);
            e  = '0;
            ln = 0;
          end
        end
        k = ntt ? k + 1 : k - 1;
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (idle_req != idle_seen) begin
      idle_seen = idle_req;
      n_vec++;
      if (m_v || m_busy || m_done || m_sl ||
          m_a0 != 0 || m_a1 != 0 || m_z != 0 ||
          m_s != 0) begin
        n_err++;
        $display("FAIL idle: v=%0b busy=%0b done=%0b a0=%h a1=%h z=%h s=%0d last=%0b, required all 0",
          m_v, m_busy, m_done, m_a0, m_a1,
          m_z, m_s, m_sl);
      end
    end
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      n_vec++;
      n_err++;
      $display("FAIL timeout: wait expired at cycle %0d, required DUT progress", cyc);
    end
    if (pend_done) begin
      pend_done = 0;
      n_vec++;
      if (!m_done) begin
        n_err++;
        $display("FAIL done_pulse: done=%0b, required 1", m_done);
      end
      n_vec++;
      if (q.size() != 0) begin
        n_err++;
        $display("FAIL leftover: %0d beats queued, required 0", q.size());
      end
      if (timed) begin
        n_vec++;
        if (cyc - st_cyc + 1 != exp_cyc) begin
          n_err++;
          $display("FAIL run_cycles: got %0d, required %0d", cyc - st_cyc + 1, exp_cyc);
        end
      end
    end else if (m_done) begin
      n_vec++;
      n_err++;
      $display("FAIL stray_done: done=1 at cycle %0d, required 0", cyc);
    end
    if (m_done) done_cnt++;
    if (gl > 0) begin
      gl--;
      n_vec++;
      if (m_v) begin
        n_err++;
        $display("FAIL gap: out_valid=1, required 0");
      end
    end else if (resume) begin
      resume = 0;
      n_vec++;
      if (!m_v) begin
        n_err++;
        $display("FAIL resume: out_valid=0, required 1");
      end
    end
    if (m_v) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL extra_beat: a0=%h, required no beat", m_a0);
      end else begin
        e = q[0];
        if (m_a0 !== e.a0 || m_a1 !== e.a1 ||
            m_z !== e.z || m_s !== e.s ||
            m_sl !== e.sl) begin
          n_err++;
          $display("FAIL beat%0d: a0=%h a1=%h z=%h s=%0d last=%0b, required a0=%h a1=%h z=%h s=%0d last=%0b",
            nbeats, m_a0, m_a1, m_z, m_s, m_sl,
            e.a0, e.a1, e.z, e.s, e.sl);
        end
        if (out_ready) begin
          void'(q.pop_front());
          nbeats++;
          if (e.fin) begin
            pend_done = 1;
          end else if (e.sl) begin
            gl     = sel ? GAP_B : 0;
            resume = 1;
          end
        end
      end
    end
  end

  task automatic kick(input bit ntt, input bit tmd);
    int lanes;
    lanes = sel ? LANES_B : 1;
    gen_run(ntt, lanes);
    @(posedge clk); #1;
    start   = 1;
    is_ntt  = ntt;
    timed   = tmd;
    exp_cyc = 2 + 7 * 128 / lanes +
              6 * (sel ? GAP_B : 0);
    st_cyc  = cyc + 1;
    @(posedge clk); #1;
    start  = 0;
    is_ntt = 1'($urandom_range(0, 1));
  endtask

  // rmode: 0 always ready, 1 random + start glitch, 2 stall at beat 10
  task automatic run(input bit ntt, input int rmode);
    int base, dc, st, n;
    bit pulsed;
    dc     = done_cnt;
    base   = nbeats + 0;
    st     = 0;
    n      = 0;
    pulsed = 0;
    out_ready = 1;
    kick(ntt, rmode == 0);
    base = nbeats;
    while (done_cnt == dc && n < 5000) begin
      start = 0;
      if (rmode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!pulsed && nbeats - base >= 50) begin
          start  = 1;
          is_ntt = ~ntt;
          pulsed = 1;
        end
      end else if (rmode == 2 &&
                   nbeats - base == 10 && st < 5) begin
        out_ready = 0;
        st++;
      end else begin
        out_ready = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    out_ready = 0;
    if (done_cnt == dc) tmo_req++;
  endtask

  task automatic wait_beats(input int base, input int tgt);
    int n;
    n = 0;
    out_ready = 1;
    while (nbeats - base < tgt && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (nbeats - base < tgt) tmo_req++;
  endtask

  initial begin
    int base;
    rst_n = 0; start = 0; is_ntt = 0;
    abort = 0; out_ready = 0; sel = 0;
    idle_req = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle_req++;

    run(1, 0);
    run(0, 0);
    run(1, 2);
    run(0, 1);

    base = nbeats;
    out_ready = 1;
    kick(1, 0);
    wait_beats(base, 300);
    abort = 1;
    out_ready = 0;
    @(posedge clk); #1;
    abort = 0;
    q.delete();
    idle_req++;
    repeat (4) @(posedge clk);

    run(1, 0);

    @(posedge clk); #1;
    start = 1;
    abort = 1;
    is_ntt = 1;
    @(posedge clk); #1;
    start = 0;
    abort = 0;
    idle_req++;
    repeat (4) @(posedge clk);

    base = nbeats;
    out_ready = 1;
    kick(0, 0);
    wait_beats(base, 100);
    rst_n = 0;
    q.delete();
    idle_req++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);

    #1 sel = 1;
    run(1, 0);
    run(0, 1);
    run(0, 0);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
